// File: rtl/cnn_pkg.sv
// Shared CNN datapath definitions: default feature-map geometry, the
// pixel-vector type, transmitter FSM states and a per-channel ReLU helper.
package cnn_pkg;

  localparam int DATA_W = 8;
  localparam int N_CH   = 16;
  localparam int IMG_H  = 28;
  localparam int IMG_W  = 28;

  // One pixel-vector: N_CH signed activations, channel 0 in the low bits.
  typedef logic signed [N_CH-1:0][DATA_W-1:0] pixvec_t;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } fmap_tx_state_t;

  // Clamp every negative channel to zero; non-negative channels pass through.
  function automatic pixvec_t relu_vec(input pixvec_t v);
    pixvec_t r;
    for (int ch = 0; ch < N_CH; ch++) begin
      r[ch] = v[ch][DATA_W-1] ? {DATA_W{1'b0}} : v[ch];
    end
    return r;
  endfunction

endpackage

// File: rtl/fmap_stream_tx_if.sv
// Bus bundle for fmap_stream_tx: pixel write port, streamed output port and
// a debug view of the FSM state.
//
// Handshake: a write is taken on a clock edge where wr_valid & wr_ready are
// both high; an output beat transfers on an edge where out_valid & out_ready
// are both high (fire). While out_valid is high and out_ready low, the
// producer keeps out_vec/out_x/out_y/out_last unchanged and does not drop
// out_valid until the beat fires.
interface fmap_stream_tx_if #(
  parameter int IMG_H = cnn_pkg::IMG_H,
  parameter int IMG_W = cnn_pkg::IMG_W
);
  import cnn_pkg::*;

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  logic           wr_valid;
  logic           wr_ready;
  logic [XW-1:0]  wr_x;
  logic [YW-1:0]  wr_y;
  pixvec_t        wr_vec;
  pixvec_t        out_vec;
  logic           out_valid;
  logic           out_ready;
  logic [XW-1:0]  out_x;
  logic [YW-1:0]  out_y;
  logic           out_last;
  logic           frame_done;
  fmap_tx_state_t dbg_state;

  modport master (
    output wr_valid, wr_x, wr_y, wr_vec, out_ready,
    input  wr_ready, out_vec, out_valid, out_x, out_y, out_last, frame_done, dbg_state
  );

  modport slave (
    input  wr_valid, wr_x, wr_y, wr_vec, out_ready,
    output wr_ready, out_vec, out_valid, out_x, out_y, out_last, frame_done, dbg_state
  );

endinterface

// File: rtl/fmap_ram.sv
// Simple dual-port frame RAM: one write port, one synchronous read port with
// a registered output. Contents and read register are not reset.
module fmap_ram #(
  parameter int DEPTH = 784,
  parameter int AW    = $clog2(DEPTH),
  parameter int W     = 128
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  // Write port and registered read port share the single clock.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/fmap_stream_tx.sv
// Feature-map transmitter: gathers one frame written in any order, then
// streams it in raster order one pixel-vector per cycle.
// Optional feature macro: FMAP_STREAM_RELU_EN (ReLU on the streamed data).
module fmap_stream_tx #(
  parameter int IMG_H = cnn_pkg::IMG_H,
  parameter int IMG_W = cnn_pkg::IMG_W
) (
  input logic             clk,
  input logic             rst_n,
  fmap_stream_tx_if.slave bus
);
  import cnn_pkg::*;

  localparam int NPIX = IMG_H * IMG_W;
  localparam int AW   = $clog2(NPIX);
  localparam int XW   = $clog2(IMG_W);
  localparam int YW   = $clog2(IMG_H);

  fmap_tx_state_t r_state;
  logic [AW-1:0]  r_wr_cnt;
  logic [AW-1:0]  r_rd_addr;
  logic [XW-1:0]  r_out_x;
  logic [YW-1:0]  r_out_y;
  logic           r_out_valid;
  logic           r_frame_done;

  logic           w_wr_fire;
  logic           w_fire;
  logic           w_last;
  logic [AW-1:0]  w_wr_addr;
  logic [AW-1:0]  w_rd_next;
  pixvec_t        w_rdata;
  pixvec_t        w_vec;

  // Only in-range coordinates in FILL are stored and counted.
  assign w_wr_fire = (r_state == FILL) && bus.wr_valid &&
                     (int'(bus.wr_x) < IMG_W) && (int'(bus.wr_y) < IMG_H);
  assign w_wr_addr = AW'(int'(bus.wr_y) * IMG_W + int'(bus.wr_x));
  assign w_fire    = r_out_valid && bus.out_ready;
  assign w_last    = (r_out_x == XW'(IMG_W - 1)) && (r_out_y == YW'(IMG_H - 1));
  // Reading the next address only on fire keeps the RAM output equal to
  // mem[r_rd_addr], so a stalled beat stays stable without extra holding.
  assign w_rd_next = w_fire ? r_rd_addr + AW'(1) : r_rd_addr;

  fmap_ram #(
    .DEPTH (NPIX),
    .AW    (AW),
    .W     (N_CH * DATA_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_fire),
    .i_waddr (w_wr_addr),
    .i_wdata (bus.wr_vec),
    .i_raddr (w_rd_next),
    .o_rdata (w_rdata)
  );

`ifdef FMAP_STREAM_RELU_EN
  assign w_vec = relu_vec(w_rdata);
`else
  assign w_vec = w_rdata;
`endif

  // FSM FILL -> PRIME -> STREAM -> FILL with write counter and raster counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= FILL;
      r_wr_cnt     <= '0;
      r_rd_addr    <= '0;
      r_out_x      <= '0;
      r_out_y      <= '0;
      r_out_valid  <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        FILL: begin
          if (w_wr_fire) begin
            if (r_wr_cnt == AW'(NPIX - 1)) begin
              r_state  <= PRIME;
              r_wr_cnt <= '0;
            end else begin
              r_wr_cnt <= r_wr_cnt + AW'(1);
            end
          end
        end
        PRIME: begin
          r_state     <= STREAM;
          r_out_valid <= 1'b1;
        end
        STREAM: begin
          if (w_fire) begin
            if (w_last) begin
              r_state      <= FILL;
              r_out_valid  <= 1'b0;
              r_frame_done <= 1'b1;
              r_rd_addr    <= '0;
              r_out_x      <= '0;
              r_out_y      <= '0;
            end else begin
              r_rd_addr <= w_rd_next;
              if (r_out_x == XW'(IMG_W - 1)) begin
                r_out_x <= '0;
                r_out_y <= r_out_y + YW'(1);
              end else begin
                r_out_x <= r_out_x + XW'(1);
              end
            end
          end
        end
        default: r_state <= FILL;
      endcase
    end
  end

  assign bus.wr_ready   = (r_state == FILL);
  assign bus.out_valid  = r_out_valid;
  assign bus.out_vec    = r_out_valid ? w_vec : '0;
  assign bus.out_x      = r_out_x;
  assign bus.out_y      = r_out_y;
  assign bus.out_last   = r_out_valid && w_last;
  assign bus.frame_done = r_frame_done;
  assign bus.dbg_state  = r_state;

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench for fmap_stream_tx: a 4x4 instance for fill order, stalls,
// ignored writes, mid-stream reset and sign handling, plus a 3x3 instance
// whose 2-bit coordinates can express out-of-range writes.
module tb_fmap_stream_tx;
  import cnn_pkg::*;

  localparam int EW = 1 + 2 + 2 + N_CH * DATA_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [EW-1:0] exp_q[$];

  fmap_stream_tx_if #(.IMG_H(4), .IMG_W(4)) if_a ();
  fmap_stream_tx_if #(.IMG_H(3), .IMG_W(3)) if_b ();

  fmap_stream_tx #(.IMG_H(4), .IMG_W(4)) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
  fmap_stream_tx #(.IMG_H(3), .IMG_W(3)) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

  logic [EW-1:0] obs_a;
  logic [EW-1:0] obs_b;
  assign obs_a = {if_a.out_last, if_a.out_y, if_a.out_x, if_a.out_vec};
  assign obs_b = {if_b.out_last, if_b.out_y, if_b.out_x, if_b.out_vec};

  // ---------------- reference data ----------------
  function automatic pixvec_t data_fn(input int kind, input int y, input int x, input int w);
    pixvec_t v;
    if (kind == 1 && y == 0 && x == 0) return {N_CH{8'hFB}};   // -5 in every channel
    if (kind == 1 && y == 0 && x == 1) return {N_CH{8'h07}};
    for (int ch = 0; ch < N_CH; ch++) begin
      v[ch] = 8'(y * w + x + ch + (kind == 2 ? 8'h40 : 0) + (kind == 3 ? 8'h20 : 0));
    end
    return v;
  endfunction

  function automatic pixvec_t exp_fn(input int kind, input int y, input int x, input int w);
    if (kind == 1 && y == 0 && x == 0) begin
`ifdef FMAP_STREAM_RELU_EN
      return '0;
`else
      return {N_CH{8'hFB}};
`endif
    end
    return data_fn(kind, y, x, w);
  endfunction

  task automatic push_frame(input int kind, input int h, input int w);
    for (int p = 0; p < h * w; p++) begin
      exp_q.push_back({1'(p == h * w - 1), 2'(p / w), 2'(p % w), exp_fn(kind, p / w, p % w, w)});
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [EW-1:0] obs, input logic [EW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, required %0h", tag, obs, exp);
    end
  endtask

  // ---------------- drivers ----------------
  task automatic drive(input bit sel, input bit v, input int x, input int y, input pixvec_t vec);
    if (sel) begin
      if_b.wr_valid = v; if_b.wr_x = 2'(x); if_b.wr_y = 2'(y); if_b.wr_vec = vec;
    end else begin
      if_a.wr_valid = v; if_a.wr_x = 2'(x); if_a.wr_y = 2'(y); if_a.wr_vec = vec;
    end
  endtask

  task automatic write_frame(input bit sel, input int h, input int w, input bit rev,
                             input int kind, input int first, input int last_n);
    for (int i = first; i < last_n; i++) begin
      int p;
      p = rev ? h * w - 1 - i : i;
      @(negedge clk);
      drive(sel, 1'b1, p % w, p / w, data_fn(kind, p / w, p % w, w));
    end
  endtask

  // Cycle after the final write: PRIME, nothing valid, writes refused.
  task automatic after_write(input bit sel, input bit garbage, input string tag);
    @(negedge clk);
    if (garbage) drive(sel, 1'b1, 3, 3, {N_CH{8'h55}});
    else         drive(sel, 1'b0, 0, 0, '0);
    check({tag, "_prime_valid"}, sel ? if_b.out_valid : if_a.out_valid, 0);
    check({tag, "_prime_wr_ready"}, sel ? if_b.wr_ready : if_a.wr_ready, 0);
  endtask

  // mode 0: out_ready held high, every cycle must carry a beat.
  // mode 1: random out_ready; stalled beats must repeat exp_q[0].
  task automatic run_stream(input bit sel, input int mode, input int n_fire,
                            input bit garbage, input string tag);
    int fires;
    int cyc;
    bit rdy;
    logic ov;
    fires = 0;
    cyc   = 0;
    while (fires < n_fire && cyc < 300) begin
      @(negedge clk);
      cyc++;
      rdy = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
      if (sel) if_b.out_ready = rdy; else if_a.out_ready = rdy;
      if (garbage) drive(sel, 1'b1, 3, 3, {N_CH{8'h55}});
      ov = sel ? if_b.out_valid : if_a.out_valid;
      if (mode == 0) check({tag, "_valid"}, ov, 1);
      if (ov) begin
        check({tag, "_beat"}, sel ? obs_b : obs_a, exp_q[0]);
        check({tag, "_wr_ready"}, sel ? if_b.wr_ready : if_a.wr_ready, 0);
        if (rdy) begin
          void'(exp_q.pop_front());
          fires++;
        end
      end
    end
    if (fires < n_fire) check({tag, "_timeout_fires"}, EW'(fires), EW'(n_fire));
  endtask

  // Cycle after the final fire: frame_done pulse, back in FILL.
  task automatic finish_check(input bit sel, input string tag);
    @(negedge clk);
    drive(sel, 1'b0, 0, 0, '0);
    check({tag, "_done"}, sel ? if_b.frame_done : if_a.frame_done, 1);
    check({tag, "_end_valid"}, sel ? if_b.out_valid : if_a.out_valid, 0);
    check({tag, "_end_wr_ready"}, sel ? if_b.wr_ready : if_a.wr_ready, 1);
    @(negedge clk);
    check({tag, "_done_pulse"}, sel ? if_b.frame_done : if_a.frame_done, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 0, 0, '0);
    drive(1, 1'b0, 0, 0, '0);
    if_a.out_ready = 1'b0;
    if_b.out_ready = 1'b0;
    repeat (3) @(negedge clk);

    // reset state
    check("rst_wr_ready", if_a.wr_ready, 1);
    check("rst_out_valid", if_a.out_valid, 0);
    check("rst_out_vec", if_a.out_vec, 0);
    check("rst_out_xy_last", {if_a.out_last, if_a.out_y, if_a.out_x}, 0);
    check("rst_frame_done", if_a.frame_done, 0);
    rst_n = 1'b1;

    // 1: raster fill, out_ready high
    write_frame(0, 4, 4, 0, 0, 0, 16);
    after_write(0, 0, "t1");
    push_frame(0, 4, 4);
    run_stream(0, 0, 16, 0, "t1");
    finish_check(0, "t1");

    // 2: reverse-order fill
    write_frame(0, 4, 4, 1, 3, 0, 16);
    after_write(0, 0, "t2");
    push_frame(3, 4, 4);
    run_stream(0, 0, 16, 0, "t2");
    finish_check(0, "t2");

    // 3: random out_ready stalls
    write_frame(0, 4, 4, 0, 2, 0, 16);
    after_write(0, 0, "t3");
    push_frame(2, 4, 4);
    run_stream(0, 1, 16, 0, "t3");
    finish_check(0, "t3");

    // 4: writes during PRIME/STREAM (aimed at the last pixel) are ignored
    write_frame(0, 4, 4, 0, 0, 0, 16);
    after_write(0, 1, "t4");
    push_frame(0, 4, 4);
    run_stream(0, 0, 16, 1, "t4");
    finish_check(0, "t4");
    write_frame(0, 4, 4, 0, 3, 0, 15);
    @(negedge clk);
    drive(0, 1'b0, 0, 0, '0);
    repeat (3) @(negedge clk);
    check("t4_partial_valid", if_a.out_valid, 0);
    check("t4_partial_wr_ready", if_a.wr_ready, 1);
    write_frame(0, 4, 4, 0, 3, 15, 16);
    after_write(0, 0, "t4b");
    push_frame(3, 4, 4);
    run_stream(0, 0, 16, 0, "t4b");
    finish_check(0, "t4b");

    // 5: reset while beat 7 is presented
    write_frame(0, 4, 4, 0, 2, 0, 16);
    after_write(0, 0, "t5");
    push_frame(2, 4, 4);
    run_stream(0, 0, 7, 0, "t5");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("t5_rst_valid", if_a.out_valid, 0);
    check("t5_rst_vec", if_a.out_vec, 0);
    check("t5_rst_xy_last", {if_a.out_last, if_a.out_y, if_a.out_x}, 0);
    check("t5_rst_wr_ready", if_a.wr_ready, 1);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    write_frame(0, 4, 4, 1, 0, 0, 16);
    after_write(0, 0, "t5b");
    push_frame(0, 4, 4);
    run_stream(0, 0, 16, 0, "t5b");
    finish_check(0, "t5b");

    // 6: negative and positive channels
    write_frame(0, 4, 4, 0, 1, 0, 16);
    after_write(0, 0, "t6");
    push_frame(1, 4, 4);
    run_stream(0, 0, 16, 0, "t6");
    finish_check(0, "t6");

    // 7: 3x3 instance, out-of-range writes interleaved with a reverse fill
    for (int i = 0; i < 8; i++) begin
      int p;
      p = 8 - i;
      @(negedge clk);
      drive(1, 1'b1, p % 3, p / 3, data_fn(0, p / 3, p % 3, 3));
      @(negedge clk);
      if (i % 2 == 0) drive(1, 1'b1, 3, 0, {N_CH{8'hAA}});
      else            drive(1, 1'b1, 0, 3, {N_CH{8'hAA}});
    end
    @(negedge clk);
    drive(1, 1'b0, 0, 0, '0);
    repeat (2) @(negedge clk);
    check("t7_partial_wr_ready", if_b.wr_ready, 1);
    check("t7_partial_valid", if_b.out_valid, 0);
    @(negedge clk);
    drive(1, 1'b1, 0, 0, data_fn(0, 0, 0, 3));
    after_write(1, 0, "t7");
    push_frame(0, 3, 3);
    run_stream(1, 0, 9, 0, "t7");
    finish_check(1, "t7");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
